// File: rtl/unidade_load_store.sv
// rtl/unidade_load_store.sv - multi-cycle load/store initiator for a word-addressed data memory
//
// Accepts one request from the core at a time, issues word-aligned memory
// cycles, extracts and extends byte/half loads and merges sub-word stores by
// read-modify-write.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 request strobe, honoured only in IDLE
//   is_store, op, addr    request kind, size code and byte address
//   store_data            store operand (low byte/half used for sub-word stores)
//   busy, done, erro      status; erro qualifies done
//   load_data             extended load result, held until the next load completes
//   mem_addr, mem_wdata   word address and write data to memory
//   mem_write             memory write enable (committed on the rising edge)
//   mem_rdata             combinational memory read data
module unidade_load_store (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        erro,
    output logic [31:0] load_data,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        is_store_q;
    logic [2:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] store_data_q;
    logic [31:0] word_q;
    logic [31:0] load_data_q;
    logic        erro_q;

    logic        req_err;
    logic        accept;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] ext_d;
    logic [31:0] merged;

    // Request check uses the live inputs because it is evaluated on the accept edge.
    always_comb begin
        req_err = 1'b0;
        case (op)
            3'b000, 3'b100: req_err = 1'b0;
            3'b001, 3'b101: req_err = addr[0];
            3'b010:         req_err = (addr[1:0] != 2'b00);
            default:        req_err = 1'b1;
        endcase
    end

    assign accept = (state_q == S_IDLE) && start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (req_err)
                        state_d = S_DONE;
                    else if (is_store && (op == 3'b010))
                        state_d = S_WRITE;
                    else
                        state_d = S_READ;
                end
            end
            S_READ:  state_d = is_store_q ? S_WRITE : S_DONE;
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane selection from the current memory word (load extract) and merge
    // of the store operand into the latched word (sub-word store).
    always_comb begin
        lane_b = 8'(mem_rdata >> {addr_q[1:0], 3'b000});
        lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   ext_d = {{24{lane_b[7] & ~op_q[2]}}, lane_b};
            2'b01:   ext_d = {{16{lane_h[15] & ~op_q[2]}}, lane_h};
            default: ext_d = mem_rdata;
        endcase

        merged = word_q;
        case (op_q[1:0])
            2'b00:   merged[{addr_q[1:0], 3'b000} +: 8]   = store_data_q[7:0];
            2'b01:   merged[{addr_q[1], 4'b0000} +: 16]   = store_data_q[15:0];
            default: merged = store_data_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            is_store_q   <= 1'b0;
            op_q         <= 3'b000;
            addr_q       <= 32'h0;
            store_data_q <= 32'h0;
            word_q       <= 32'h0;
            load_data_q  <= 32'h0;
            erro_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_store_q   <= is_store;
                op_q         <= op;
                addr_q       <= addr;
                store_data_q <= store_data;
                erro_q       <= req_err;
            end
            if (state_q == S_READ) begin
                if (is_store_q)
                    word_q <= mem_rdata;
                else
                    load_data_q <= ext_d;
            end
        end
    end

    // Write strobe and data are decoded from state so that an asynchronous
    // reset during WRITE removes them before the next edge.
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign erro      = (state_q == S_DONE) && erro_q;
    assign mem_write = (state_q == S_WRITE);
    assign mem_wdata = (state_q == S_WRITE) ? merged : 32'h0;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign load_data = load_data_q;

endmodule

// File: doc/unidade_load_store.md
# unidade_load_store

Multi-cycle load/store initiator between the MIPS datapath and the word-addressed data memory. Accepts one request at a time from the core, issues word-aligned read/write cycles on the memory port, and performs byte/halfword extraction with sign/zero extension for loads and read-modify-write merging for sub-word stores. The memory port matches the data memory: combinational read, write committed on the rising clock edge when the write enable is high.

## Interface
Parameters:
- none; all widths fixed at 32 bits, byte addressing, little-endian lanes.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request strobe, sampled only in IDLE
- is_store  in  1  1 = store, 0 = load
- op  in  3  size code: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 invalid
- addr  in  32  byte address of the access
- store_data  in  32  store operand; byte/half taken from bits [7:0]/[15:0]
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- erro  out  1  valid with done; misaligned address or invalid op
- load_data  out  32  extended load result, held until next load completes
- mem_addr  out  32  word address to memory, {addr_q[31:2], 2'b00}
- mem_wdata  out  32  word written to memory
- mem_write  out  1  memory write enable
- mem_rdata  in  32  combinational read data from memory

## Operation
- Request fields (is_store, op, addr, store_data) are registered on the edge where start=1 in IDLE; inputs are ignored at all other times.
- States: IDLE, READ, WRITE, DONE.
- Check at accept: half requires addr[0]=0, word requires addr[1:0]=00; invalid op or misalignment → DONE directly with erro=1; no memory access, load_data unchanged.
- Load: IDLE→READ→DONE. On the READ→DONE edge the selected lane of mem_rdata is extracted and extended into load_data.
- Store word: IDLE→WRITE→DONE; mem_wdata = store_data_q.
- Store byte/half: IDLE→READ→WRITE→DONE. The word read in READ is latched; in WRITE mem_wdata = that word with the target lane replaced by store_data_q[7:0] or [15:0]; other lanes unchanged.
- Lanes: byte offset addr[1:0] selects bits [8k+7:8k]; half uses addr[1]: 0 → [15:0], 1 → [31:16].
- Signed ops replicate the lane MSB into the upper bits; unsigned ops fill with zeros.
- DONE always returns to IDLE on the next edge; done=1 only in DONE; a start asserted in DONE is ignored.
- mem_write=1 only in WRITE. mem_addr is stable from READ/WRITE through DONE and is 0 in IDLE after reset.

## Timing
- Cycle 0 = cycle in which start=1 is sampled in IDLE.
- Load: READ cycle 1, done in cycle 2, load_data valid from cycle 2.
- Store word: mem_write high in cycle 1 (memory commits at the end of cycle 1), done in cycle 2.
- Store byte/half: READ cycle 1, WRITE cycle 2, done in cycle 3.
- Error: done with erro=1 in cycle 1.
- Back-to-back: next start accepted in the cycle after DONE (IDLE); minimum request spacing is latency+1.
- Reset (rst_n=0, any time): immediately state=IDLE, busy=0, done=0, erro=0, mem_write=0, mem_wdata=0, mem_addr=0, load_data=0. A reset during WRITE must drop mem_write before the next edge, so no write is committed. Operation resumes on the first edge with rst_n=1.

## Test plan
- Load word: mem[0x10]=0xDEADBEEF, start load op=010 addr=0x40 → done in cycle 2, load_data=0xDEADBEEF, erro=0, mem_write never high.
- Sign/zero extension: same word, op=000 addr=0x43 → 0xFFFFFFDE; op=100 addr=0x43 → 0x000000DE; op=001 addr=0x42 → 0xFFFFDEAD; op=101 addr=0x40 → 0x0000BEEF.
- Store byte RMW: mem[0x10]=0x11223344, store op=000 addr=0x41 data=0xAB → mem_write only in cycle 2 with mem_wdata=0x1122AB44, done in cycle 3; a subsequent load word reads 0x1122AB44.
- Store half/word: store op=001 addr=0x42 data=0xCAFE on 0x11223344 → 0xCAFE3344 at cycle 3; store word addr=0x44 data=0x01020304 → mem_write in cycle 1, done in cycle 2.
- Errors: load word addr=0x42, store half addr=0x41, op=011 → done with erro=1 in cycle 1, no mem_write, load_data unchanged; start held high while busy → exactly one request executes.
- Reset mid-store: assert rst_n=0 during the WRITE cycle of a byte store → mem_write falls immediately, memory word unchanged, all outputs 0, new request completes normally after release.
